// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the decode-stage register file.
package regfile_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int REG_NUM_DEF   = 32;
    localparam int ADDR_SIZE_DEF = 5;
    localparam int IMM_W_DEF     = 11;
    localparam int PC_W_DEF      = 5;
    localparam int SB_W_DEF      = 2;

    // Architectural zero register.
    localparam int R0 = 0;

    // Widest datapath the zero-extend helper supports.
    localparam int ZEXT_W = 64;

    // Keeps the low w bits of v and clears everything above them.
    // Callers cast the result down to their own XLEN.
    function automatic logic [ZEXT_W-1:0] zext_to_xlen(input logic [ZEXT_W-1:0] v,
                                                       input int w);
        logic [ZEXT_W-1:0] mask;
        mask = (w >= ZEXT_W) ? '1 : ((ZEXT_W'(1) << w) - ZEXT_W'(1));
        return v & mask;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus seen by the register file.
interface regfile_sb_if #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 5,
    parameter int IMM_W     = 11,
    parameter int PC_W      = 5
);
    // decode-side request
    logic [ADDR_SIZE-1:0] D_ra;
    logic [ADDR_SIZE-1:0] D_rb;
    logic [ADDR_SIZE-1:0] D_rd;
    logic [IMM_W-1:0]     D_imd;
    logic [PC_W-1:0]      D_pc;
    logic                 D_ld;
    logic                 D_str;
    logic                 D_brn;
    logic                 D_use_ra;
    logic                 D_use_rb;
    logic                 D_wr;
    logic                 D_issue;
    // writeback
    logic                 WB_we;
    logic [ADDR_SIZE-1:0] WB_rd;
    logic [XLEN-1:0]      WB_data_mem;
    // operands and issue control back to decode
    logic [XLEN-1:0]      D_a;
    logic [XLEN-1:0]      D_b;
    logic [XLEN-1:0]      D_a2;
    logic [XLEN-1:0]      D_b2;
    logic                 D_stall;
    logic                 D_accept;

    modport master (
        output D_ra, D_rb, D_rd, D_imd, D_pc, D_ld, D_str, D_brn,
               D_use_ra, D_use_rb, D_wr, D_issue, WB_we, WB_rd, WB_data_mem,
        input  D_a, D_b, D_a2, D_b2, D_stall, D_accept
    );

    modport slave (
        input  D_ra, D_rb, D_rd, D_imd, D_pc, D_ld, D_str, D_brn,
               D_use_ra, D_use_rb, D_wr, D_issue, WB_we, WB_rd, WB_data_mem,
        output D_a, D_b, D_a2, D_b2, D_stall, D_accept
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters; blocks issue on RAW hazards and
// on a destination whose counter is already saturated.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int REG_NUM   = REG_NUM_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int SB_W      = SB_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_use_ra,
    input  logic                 D_use_rb,
    input  logic                 D_wr,
    input  logic                 D_issue,
    input  logic                 WB_we,
    input  logic [ADDR_SIZE-1:0] WB_rd,
    output logic                 D_stall,
    output logic                 D_accept
);

    logic [REG_NUM-1:0][SB_W-1:0] cnt_q, cnt_d;
    logic [REG_NUM-1:0]           ret;       // same-cycle WB retires one pending write
    logic [REG_NUM-1:0]           eff_busy;  // pending count after that retirement is non-zero
    logic [REG_NUM-1:0]           full;      // counter at all-ones, cannot take another write
    logic                         busy_a, busy_b, full_rd;

    // Per-register retirement / busy / full flags. r0 is never busy.
    always_comb begin
        ret      = '0;
        eff_busy = '0;
        full     = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            ret[r]      = WB_we && (WB_rd == ADDR_SIZE'(r)) && (cnt_q[r] != '0);
            eff_busy[r] = ret[r] ? (cnt_q[r] != SB_W'(1)) : (cnt_q[r] != '0);
            full[r]     = &cnt_q[r];
        end
    end

    // Select the flags for the addressed registers; out-of-range indices match nothing.
    always_comb begin
        busy_a  = 1'b0;
        busy_b  = 1'b0;
        full_rd = 1'b0;
        for (int r = 1; r < REG_NUM; r++) begin
            if (D_ra == ADDR_SIZE'(r)) busy_a  = eff_busy[r];
            if (D_rb == ADDR_SIZE'(r)) busy_b  = eff_busy[r];
            if (D_rd == ADDR_SIZE'(r)) full_rd = full[r];
        end
    end

    assign D_stall  = D_issue && ((D_use_ra && busy_a) || (D_use_rb && busy_b) ||
                                  (D_wr && full_rd));
    assign D_accept = D_issue && !D_stall;

    // Counter next state: accepted write issues increment, retirements decrement,
    // both together cancel out.
    always_comb begin
        cnt_d     = cnt_q;
        cnt_d[R0] = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            if (D_accept && D_wr && (D_rd == ADDR_SIZE'(r)) && !ret[r])
                cnt_d[r] = cnt_q[r] + SB_W'(1);
            else if (ret[r] && !(D_accept && D_wr && (D_rd == ADDR_SIZE'(r))))
                cnt_d[r] = cnt_q[r] - SB_W'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file with WB write-through bypass, operand muxes
// and a pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_NUM   = REG_NUM_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int IMM_W     = IMM_W_DEF,
    parameter int PC_W      = PC_W_DEF,
    parameter int SB_W      = SB_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    typedef logic [REG_NUM-1:0][XLEN-1:0] regs_t;

    regs_t           regs_q, regs_d;
    logic [XLEN-1:0] rd_a, rd_b;
    logic            stall, accept;

    // Read port: r0 and out-of-range read 0, a same-cycle WB to the index wins.
    function automatic logic [XLEN-1:0] read_port(input logic [ADDR_SIZE-1:0] idx,
                                                  input regs_t               regs,
                                                  input logic                we,
                                                  input logic [ADDR_SIZE-1:0] wrd,
                                                  input logic [XLEN-1:0]     wdata);
        logic [XLEN-1:0] v;
        v = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            if (idx == ADDR_SIZE'(r)) v = (we && wrd == idx) ? wdata : regs[r];
        end
        return v;
    endfunction

    // Writeback into storage; r0 and out-of-range targets are dropped.
    always_comb begin
        regs_d     = regs_q;
        regs_d[R0] = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            if (bus.WB_we && bus.WB_rd == ADDR_SIZE'(r)) regs_d[r] = bus.WB_data_mem;
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (rst) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    // Both read ports with bypass.
    always_comb begin
        rd_a = read_port(bus.D_ra, regs_q, bus.WB_we, bus.WB_rd, bus.WB_data_mem);
        rd_b = read_port(bus.D_rb, regs_q, bus.WB_we, bus.WB_rd, bus.WB_data_mem);
    end

    assign bus.D_a2 = rd_a;
    assign bus.D_b2 = rd_b;
    assign bus.D_a  = bus.D_brn ? XLEN'(zext_to_xlen(ZEXT_W'(bus.D_pc), PC_W)) : rd_a;
    assign bus.D_b  = (bus.D_ld || bus.D_str || bus.D_brn)
                    ? XLEN'(zext_to_xlen(ZEXT_W'(bus.D_imd), IMM_W)) : rd_b;

    rf_scoreboard #(
        .REG_NUM  (REG_NUM),
        .ADDR_SIZE(ADDR_SIZE),
        .SB_W     (SB_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .D_ra     (bus.D_ra),
        .D_rb     (bus.D_rb),
        .D_rd     (bus.D_rd),
        .D_use_ra (bus.D_use_ra),
        .D_use_rb (bus.D_use_rb),
        .D_wr     (bus.D_wr),
        .D_issue  (bus.D_issue),
        .WB_we    (bus.WB_we),
        .WB_rd    (bus.WB_rd),
        .D_stall  (stall),
        .D_accept (accept)
    );

    assign bus.D_stall  = stall;
    assign bus.D_accept = accept;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios followed by random traffic, all
// checked against an array-based reference model.
module tb_regfile_sb;

    localparam int NREG = 24;   // smaller than 2**5 so out-of-range indices exist
    localparam int CMAX = 3;    // 2**SB_W - 1

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    int   regs_m [32];
    int   cnt_m  [32];

    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .ADDR_SIZE(5), .IMM_W(11), .PC_W(5)) bus();

    regfile_sb #(.XLEN(32), .REG_NUM(NREG), .ADDR_SIZE(5), .IMM_W(11), .PC_W(5), .SB_W(2))
        dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 0 || idx >= NREG) return 32'h0;
        if (bus.WB_we && int'(bus.WB_rd) == idx) return bus.WB_data_mem;
        return regs_m[idx];
    endfunction

    function automatic bit m_busy(input int r);
        int e;
        if (r == 0 || r >= NREG) return 1'b0;
        e = cnt_m[r] - ((bus.WB_we && int'(bus.WB_rd) == r && cnt_m[r] != 0) ? 1 : 0);
        return e != 0;
    endfunction

    function automatic bit m_stall();
        int rd;
        rd = int'(bus.D_rd);
        return bus.D_issue && ((bus.D_use_ra && m_busy(int'(bus.D_ra))) ||
                               (bus.D_use_rb && m_busy(int'(bus.D_rb))) ||
                               (bus.D_wr && rd != 0 && rd < NREG && cnt_m[rd] == CMAX));
    endfunction

    task automatic check_outputs();
        logic [31:0] ea, eb;
        bit st;
        ea = m_read(int'(bus.D_ra));
        eb = m_read(int'(bus.D_rb));
        st = m_stall();
        chk("D_a2", bus.D_a2, ea);
        chk("D_b2", bus.D_b2, eb);
        chk("D_a", bus.D_a, bus.D_brn ? 32'(bus.D_pc) : ea);
        chk("D_b", bus.D_b, (bus.D_ld || bus.D_str || bus.D_brn) ? 32'(bus.D_imd) : eb);
        chk("D_stall", 32'(bus.D_stall), 32'(st));
        chk("D_accept", 32'(bus.D_accept), 32'(bus.D_issue && !st));
    endtask

    // Advance one clock, applying the specification's update rules to the model.
    task automatic tick();
        int  nregs [32];
        int  ncnt  [32];
        bit  acc;
        int  wrd, drd;
        nregs = regs_m;
        ncnt  = cnt_m;
        acc   = bus.D_issue && !m_stall();
        wrd   = int'(bus.WB_rd);
        drd   = int'(bus.D_rd);
        if (rst) begin
            foreach (nregs[i]) begin nregs[i] = 0; ncnt[i] = 0; end
        end else begin
            if (bus.WB_we && wrd != 0 && wrd < NREG) nregs[wrd] = bus.WB_data_mem;
            for (int r = 1; r < NREG; r++) begin
                int inc, dec;
                inc = (acc && bus.D_wr && drd == r) ? 1 : 0;
                dec = (bus.WB_we && wrd == r && cnt_m[r] != 0) ? 1 : 0;
                ncnt[r] = cnt_m[r] + inc - dec;
            end
        end
        @(posedge clk);
        regs_m = nregs;
        cnt_m  = ncnt;
        @(negedge clk);
    endtask

    task automatic cyc();
        #1 check_outputs();
        tick();
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.D_ra = '0; bus.D_rb = '0; bus.D_rd = '0; bus.D_imd = '0; bus.D_pc = '0;
        bus.D_ld = 1'b0; bus.D_str = 1'b0; bus.D_brn = 1'b0;
        bus.D_use_ra = 1'b0; bus.D_use_rb = 1'b0; bus.D_wr = 1'b0; bus.D_issue = 1'b0;
        bus.WB_we = 1'b0; bus.WB_rd = '0; bus.WB_data_mem = '0;
    endtask

    task automatic wb(input int r, input logic [31:0] d);
        bus.WB_we = 1'b1; bus.WB_rd = 5'(r); bus.WB_data_mem = d;
    endtask

    task automatic issue_wr(input int r);
        bus.D_issue = 1'b1; bus.D_wr = 1'b1; bus.D_rd = 5'(r);
    endtask

    task automatic issue_rd(input int r);
        bus.D_issue = 1'b1; bus.D_use_ra = 1'b1; bus.D_ra = 5'(r);
    endtask

    initial begin
        foreach (regs_m[i]) begin regs_m[i] = 0; cnt_m[i] = 0; end
        idle();
        rst = 1'b1;
        tick();                         // storage is unknown until the first reset edge

        // Reset state: reads return 0, no stall.
        rst = 1'b1; issue_rd(5); bus.D_rb = 5'd9; bus.D_use_rb = 1'b1;
        #1 chk("rst_D_a2", bus.D_a2, 32'h0);
        chk("rst_stall", 32'(bus.D_stall), 32'h0);
        cyc();

        // 1: plain write/read, r0 stays zero.
        idle(); wb(5, 32'hDEADBEEF); cyc();
        idle(); bus.D_ra = 5'd5;
        #1 chk("r5_D_a", bus.D_a, 32'hDEADBEEF);
        chk("r5_D_a2", bus.D_a2, 32'hDEADBEEF);
        cyc();
        idle(); wb(0, 32'h1234); cyc();
        idle(); bus.D_ra = 5'd0;
        #1 chk("r0_read", bus.D_a2, 32'h0);
        cyc();

        // 2: same-cycle bypass.
        idle(); wb(7, 32'hA5A5A5A5); bus.D_ra = 5'd7;
        #1 chk("bypass", bus.D_a2, 32'hA5A5A5A5);
        cyc();

        // 3: operand muxes.
        idle(); bus.D_brn = 1'b1; bus.D_pc = 5'd19; bus.D_imd = 11'h7FF;
        bus.D_ra = 5'd5; bus.D_rb = 5'd7;
        #1 chk("brn_D_a", bus.D_a, 32'd19);
        chk("brn_D_b", bus.D_b, 32'h7FF);
        chk("brn_D_a2", bus.D_a2, 32'hDEADBEEF);
        chk("brn_D_b2", bus.D_b2, 32'hA5A5A5A5);
        cyc();
        bus.D_brn = 1'b0; bus.D_ld = 1'b1;
        #1 chk("ld_D_b", bus.D_b, 32'h7FF);
        chk("ld_D_a", bus.D_a, 32'hDEADBEEF);
        cyc();

        // 4: RAW stall, released by a same-cycle WB.
        idle(); issue_wr(3);
        #1 chk("wr3_accept", 32'(bus.D_accept), 32'h1);
        cyc();
        idle(); issue_rd(3);
        #1 chk("raw_stall", 32'(bus.D_stall), 32'h1);
        chk("raw_accept", 32'(bus.D_accept), 32'h0);
        cyc();
        wb(3, 32'h33);
        #1 chk("wb_release", 32'(bus.D_stall), 32'h0);
        chk("wb_bypass", bus.D_a2, 32'h33);
        cyc();
        idle(); issue_rd(3);
        #1 chk("r3_free", 32'(bus.D_stall), 32'h0);
        cyc();

        // 5: saturation, simultaneous inc/dec, orphan WB.
        idle(); issue_wr(9); cyc(); cyc(); cyc();
        #1 chk("sat_stall", 32'(bus.D_stall), 32'h1);
        cyc();
        idle(); wb(9, 32'h9); cyc();                   // cnt 3 -> 2
        issue_wr(9); cyc();                            // inc + dec -> still 2
        idle(); issue_wr(9);
        #1 chk("cnt2_accept", 32'(bus.D_accept), 32'h1);
        cyc();                                         // -> 3
        #1 chk("cnt3_stall", 32'(bus.D_stall), 32'h1);
        cyc();
        idle(); wb(9, 32'h90); cyc(); cyc(); cyc();    // drain
        idle(); wb(4, 32'h44); cyc();
        idle(); issue_rd(4);
        #1 chk("orphan_stall", 32'(bus.D_stall), 32'h0);
        chk("orphan_data", bus.D_a2, 32'h44);
        cyc();
        idle(); issue_rd(9);
        #1 chk("r9_drained", 32'(bus.D_stall), 32'h0);
        cyc();

        // 6: mid-operation reset drops the concurrent WB and clears everything.
        idle(); wb(3, 32'h55); cyc();
        idle(); issue_wr(3); cyc(); cyc();
        idle(); rst = 1'b1; wb(3, 32'h99); issue_wr(3); cyc();
        idle(); issue_rd(3);
        #1 chk("post_rst_r3", bus.D_a2, 32'h0);
        chk("post_rst_stall", 32'(bus.D_stall), 32'h0);
        cyc();

        // Out-of-range indices: read 0, writes dropped, never busy.
        idle(); wb(28, 32'hCAFE); cyc();
        idle(); bus.D_ra = 5'd28; issue_wr(28);
        #1 chk("oor_read", bus.D_a2, 32'h0);
        cyc();
        idle(); issue_rd(28);
        #1 chk("oor_busy", 32'(bus.D_stall), 32'h0);
        cyc();

        // Random traffic over a small hot set of registers.
        for (int n = 0; n < 600; n++) begin
            int pick;
            idle();
            rst = ($urandom_range(0, 79) == 0);
            pick = $urandom_range(0, 3);
            bus.D_ra  = 5'((pick == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4));
            pick = $urandom_range(0, 3);
            bus.D_rb  = 5'((pick == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4));
            pick = $urandom_range(0, 3);
            bus.D_rd  = 5'((pick == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4));
            bus.D_imd = 11'($urandom);
            bus.D_pc  = 5'($urandom);
            bus.D_ld  = 1'($urandom); bus.D_str = 1'($urandom); bus.D_brn = 1'($urandom);
            bus.D_use_ra = 1'($urandom); bus.D_use_rb = 1'($urandom);
            bus.D_wr     = 1'($urandom); bus.D_issue  = ($urandom_range(0, 3) != 0);
            bus.WB_we    = 1'($urandom);
            pick = $urandom_range(0, 3);
            bus.WB_rd    = 5'((pick == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4));
            bus.WB_data_mem = $urandom;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the decode-stage register file: generalised immediate/PC widths, synchronous reset, a WB→decode write-through bypass, and a per-register pending-write scoreboard.
- Sits between the decode stage and the WB flops.
- Supplies raw operands (D_a2/D_b2) and ALU-muxed operands (D_a/D_b).
- Raises D_stall when an issuing instruction reads a register with an outstanding write.

Parameters:
- XLEN, 32, datapath width.
- REG_NUM, 32, number of architectural registers.
- ADDR_SIZE, 5, register index width; REG_NUM <= 2**ADDR_SIZE.
- IMM_W, 11, immediate width, zero-extended to XLEN; IMM_W <= XLEN.
- PC_W, 5, PC width, zero-extended to XLEN; PC_W <= XLEN.
- SB_W, 2, pending-write counter width per register; max in-flight writes per register = 2**SB_W-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- D_ra  in  ADDR_SIZE  first source register.
- D_rb  in  ADDR_SIZE  second source register.
- D_rd  in  ADDR_SIZE  destination of the issuing instruction.
- D_imd  in  IMM_W  immediate.
- D_pc  in  PC_W  decode-stage PC.
- D_ld / D_str / D_brn  in  1 each  instruction class.
- D_use_ra / D_use_rb  in  1 each  instruction actually reads ra / rb.
- D_wr  in  1  instruction will write D_rd.
- D_issue  in  1  decode requests issue this cycle.
- WB_we  in  1  writeback enable.
- WB_rd  in  ADDR_SIZE  writeback register.
- WB_data_mem  in  XLEN  writeback data.
- D_a  out  XLEN  D_brn ? zext(D_pc) : rd_a.
- D_b  out  XLEN  (D_ld|D_str|D_brn) ? zext(D_imd) : rd_b.
- D_a2 / D_b2  out  XLEN  rd_a / rd_b, unmuxed.
- D_stall  out  1  issue blocked this cycle.
- D_accept  out  1  D_issue & ~D_stall.

Behaviour:
- Storage: regs[0..REG_NUM-1], cnt[0..REG_NUM-1] (SB_W bits each).
- Reset (rst=1 at posedge): all regs and all cnt := 0. Nothing else updates that cycle; a WB or issue in the reset cycle is dropped.
- Outputs are combinational with zero latency. After reset, every read returns 0 and D_stall=0.
- Write: at posedge, if WB_we & WB_rd!=0 & WB_rd<REG_NUM, then regs[WB_rd] := WB_data_mem. regs[0] is constant 0; a write to r0 is ignored.
- Read: rd_a = 0 if D_ra==0 or D_ra>=REG_NUM. Else WB_data_mem if WB_we & WB_rd==D_ra. Else regs[D_ra]. rd_b is identical with D_rb.
- Effective pending count: eff(r) = cnt[r] - (WB_we & WB_rd==r & cnt[r]!=0). A same-cycle WB retires one pending write; its data reaches decode through the bypass.
- D_stall = D_issue & ( (D_use_ra & D_ra!=0 & eff(D_ra)!=0) | (D_use_rb & D_rb!=0 & eff(D_rb)!=0) | (D_wr & D_rd!=0 & cnt[D_rd]==all-ones) ).
- D_stall is 0 when D_issue=0.
- Counter update per register r at posedge (not in reset):
  - inc = D_accept & D_wr & D_rd==r & r!=0
  - dec = WB_we & WB_rd==r & cnt[r]!=0
  - inc & ~dec: cnt[r]+1
  - dec & ~inc: cnt[r]-1
  - both, or neither: unchanged
- WB to a register with cnt=0 (orphan write): data is written, cnt stays 0 (no underflow).
- cnt[0] is always 0.
- Saturation: cnt never wraps. The issue is stalled instead (third term of D_stall).
- Out-of-range indices (>=REG_NUM) read as 0, are never busy, and their writes are ignored.

Decomposition:
- Package regfile_pkg: default XLEN/ADDR_SIZE/IMM_W/PC_W/SB_W, the R0 index constant, and a function zext_to_xlen.
- Sub-module rf_scoreboard holds the cnt array plus the inc/dec/saturation logic.
  - Inputs: clk, rst, D_ra, D_rb, D_rd, D_use_ra, D_use_rb, D_wr, D_issue, WB_we, WB_rd.
  - Outputs: D_stall, D_accept.
- regfile_sb instantiates rf_scoreboard and holds storage, bypass and operand muxes.

Test Plan:
1. Reset, then write r5=0xDEADBEEF; next cycle D_ra=5, D_brn=0 → D_a=D_a2=0xDEADBEEF. Write r0=0x1234 → read r0 returns 0.
2. Bypass: WB_we=1, WB_rd=7, WB_data_mem=0xA5A5A5A5 in the same cycle as D_ra=7 → D_a2=0xA5A5A5A5 that cycle.
3. Operand mux: D_brn=1, D_pc=5'd19, D_imd=11'h7FF → D_a=19, D_b=0x7FF, D_a2/D_b2 still raw register values. D_ld=1 alone → D_b=zext(D_imd), D_a=regs[D_ra].
4. Scoreboard stall:
   - Issue with D_wr=1, D_rd=3 → cnt[3]=1.
   - Next cycle, issue with D_use_ra=1, D_ra=3 → D_stall=1, D_accept=0.
   - WB to r3 arrives in the stalled cycle → D_stall=0, bypass data delivered, cnt[3]=0.
5. Saturation and simultaneous events (SB_W=2):
   - Issue writes to r9 on three consecutive cycles → cnt=3; a fourth D_wr issue to r9 → D_stall=1.
   - Issue+WB to r9 in the same cycle with cnt=2 → cnt stays 2.
   - Orphan WB to r4 with cnt=0 → data written, cnt stays 0.
6. Mid-operation reset: cnt[3]=2 and r3=0x55, assert rst for one cycle with WB_we=1 to r3 → afterwards r3 reads 0, cnt[3]=0, no stall on reading r3.
